// File: rtl/instr_pkg.sv
// Shared instruction-encoding definitions: widths, opcode constants and the
// function-index to opcode map used by both the encoder and the decoder.
package instr_pkg;

    localparam int OP_W = 4;
    localparam int FN_N = 14;

    localparam logic [OP_W-1:0] OP_F0  = 4'h0;
    localparam logic [OP_W-1:0] OP_F1  = 4'h1;
    localparam logic [OP_W-1:0] OP_F2  = 4'h2;
    localparam logic [OP_W-1:0] OP_F3  = 4'h3;
    localparam logic [OP_W-1:0] OP_F4  = 4'h4;
    localparam logic [OP_W-1:0] OP_F5  = 4'h5;
    localparam logic [OP_W-1:0] OP_F6  = 4'h6;
    localparam logic [OP_W-1:0] OP_F7  = 4'h7;
    localparam logic [OP_W-1:0] OP_F8  = 4'h8;
    localparam logic [OP_W-1:0] OP_F9  = 4'hA;
    localparam logic [OP_W-1:0] OP_F10 = 4'hB;
    localparam logic [OP_W-1:0] OP_F11 = 4'hC;
    localparam logic [OP_W-1:0] OP_F12 = 4'hD;
    localparam logic [OP_W-1:0] OP_F13 = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } enc_state_t;

    // Opcodes 0x9 and 0xE are reserved; out-of-range indices fold to OP_F0.
    function automatic logic [OP_W-1:0] fn_to_op(input logic [3:0] idx);
        logic [OP_W-1:0] op;
        case (idx)
            4'd0:    op = OP_F0;
            4'd1:    op = OP_F1;
            4'd2:    op = OP_F2;
            4'd3:    op = OP_F3;
            4'd4:    op = OP_F4;
            4'd5:    op = OP_F5;
            4'd6:    op = OP_F6;
            4'd7:    op = OP_F7;
            4'd8:    op = OP_F8;
            4'd9:    op = OP_F9;
            4'd10:   op = OP_F10;
            4'd11:   op = OP_F11;
            4'd12:   op = OP_F12;
            4'd13:   op = OP_F13;
            default: op = OP_F0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_bit_pick.sv
// Combinational priority picker over a pending function vector: selected
// index, one-hot clear mask, and whether exactly one bit is set.
module instr_bit_pick
    import instr_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic [FN_N-1:0] pend,
    output logic [3:0]      sel_idx,
    output logic [FN_N-1:0] clr_mask,
    output logic            single
);

    logic [3:0] idx_s;

    // Scan so the last match written is the winning priority.
    always_comb begin
        idx_s = 4'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < FN_N; i++) begin
                idx_s = pend[i] ? 4'(i) : idx_s;
            end
        end else begin
            for (int i = FN_N - 1; i >= 0; i--) begin
                idx_s = pend[i] ? 4'(i) : idx_s;
            end
        end
    end

    assign sel_idx  = idx_s;
    assign clr_mask = (pend != 14'd0) ? (14'd1 << idx_s) : 14'd0;
    assign single   = (pend != 14'd0) && ((pend & (pend - 14'd1)) == 14'd0);

endmodule

// File: rtl/instruction_encoder_seq.sv
// Sequential instruction encoder: accepts a multi-hot function vector and
// streams one registered opcode per handshake, with zero-bubble chaining.
module instruction_encoder_seq
    import instr_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] in_f,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  op_code,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        op_last,
    output logic        err_empty
);

    enc_state_t      state_r, state_n_s;
    logic [FN_N-1:0] pend_r, pend_n_s;
    logic [OP_W-1:0] op_code_r, code_n_s;
    logic            op_valid_r, valid_n_s;
    logic            op_last_r, last_n_s;
    logic            err_r, err_n_s;

    logic            hs_s, acc_s, load_s, in_ready_s;
    logic [FN_N-1:0] pick_src_s, clr_mask_s;
    logic [3:0]      sel_idx_s;
    logic            single_s;

    // pend_r holds the bits not yet shown on op_code; the shown one is already cleared.
    assign hs_s       = op_valid_r && op_ready;
    assign in_ready_s = (state_r == ST_IDLE) ||
                        ((state_r == ST_EMIT) && op_ready && op_last_r);
    assign acc_s      = in_valid && in_ready_s;
    assign load_s     = acc_s && (in_f != 14'd0);
    assign pick_src_s = load_s ? in_f : pend_r;

    instr_bit_pick #(.HIGH_FIRST(HIGH_FIRST)) u_pick (
        .pend     (pick_src_s),
        .sel_idx  (sel_idx_s),
        .clr_mask (clr_mask_s),
        .single   (single_s)
    );

    // Next-state, pending and output-register update.
    always_comb begin
        state_n_s = state_r;
        pend_n_s  = pend_r;
        code_n_s  = op_code_r;
        valid_n_s = op_valid_r;
        last_n_s  = op_last_r;
        err_n_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_n_s = ST_EMIT;
                    pend_n_s  = pick_src_s & ~clr_mask_s;
                    code_n_s  = fn_to_op(sel_idx_s);
                    valid_n_s = 1'b1;
                    last_n_s  = single_s;
                end else begin
                    err_n_s = acc_s;
                end
            end
            ST_EMIT: begin
                if (hs_s && (load_s || !op_last_r)) begin
                    pend_n_s  = pick_src_s & ~clr_mask_s;
                    code_n_s  = fn_to_op(sel_idx_s);
                    valid_n_s = 1'b1;
                    last_n_s  = single_s;
                end else if (hs_s) begin
                    state_n_s = ST_IDLE;
                    pend_n_s  = 14'd0;
                    code_n_s  = 4'h0;
                    valid_n_s = 1'b0;
                    last_n_s  = 1'b0;
                    err_n_s   = acc_s;
                end else begin
                    state_n_s = ST_EMIT;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                pend_n_s  = 14'd0;
                code_n_s  = 4'h0;
                valid_n_s = 1'b0;
                last_n_s  = 1'b0;
            end
        endcase
    end

    // State, pending vector and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pend_r     <= 14'd0;
            op_code_r  <= 4'h0;
            op_valid_r <= 1'b0;
            op_last_r  <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            pend_r     <= pend_n_s;
            op_code_r  <= code_n_s;
            op_valid_r <= valid_n_s;
            op_last_r  <= last_n_s;
            err_r      <= err_n_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign op_code   = op_code_r;
    assign op_valid  = op_valid_r;
    assign op_last   = op_last_r;
    assign err_empty = err_r;

endmodule

// File: tb/tb_instruction_encoder_seq.sv
// Scoreboard bench: low-first and high-first encoders driven in parallel,
// expected opcode streams queued on accept and popped on each handshake.
module tb_instruction_encoder_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] in_f;
    logic        in_valid;
    logic        op_ready;
    logic        lo_in_ready, hi_in_ready;
    logic [3:0]  lo_op_code, hi_op_code;
    logic        lo_op_valid, hi_op_valid;
    logic        lo_op_last, hi_op_last;
    logic        lo_err_empty, hi_err_empty;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0]  lo_q[$];
    logic [4:0]  hi_q[$];
    logic [3:0]  op_map[14];
    logic        exp_err;

    always #5 clk = ~clk;

    instruction_encoder_seq #(.HIGH_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .in_f(in_f), .in_valid(in_valid),
        .in_ready(lo_in_ready), .op_code(lo_op_code), .op_valid(lo_op_valid),
        .op_ready(op_ready), .op_last(lo_op_last), .err_empty(lo_err_empty)
    );

    instruction_encoder_seq #(.HIGH_FIRST(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .in_f(in_f), .in_valid(in_valid),
        .in_ready(hi_in_ready), .op_code(hi_op_code), .op_valid(hi_op_valid),
        .op_ready(op_ready), .op_last(hi_op_last), .err_empty(hi_err_empty)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {last, code} stream for a vector in both emission orders.
    task automatic push_vec(input logic [13:0] v);
        logic [4:0] lo_s[$];
        logic [4:0] hi_s[$];
        for (int i = 0; i < 14; i++) begin
            if (v[i]) lo_s.push_back({1'b0, op_map[i]});
        end
        for (int i = 13; i >= 0; i--) begin
            if (v[i]) hi_s.push_back({1'b0, op_map[i]});
        end
        lo_s[lo_s.size()-1][4] = 1'b1;
        hi_s[hi_s.size()-1][4] = 1'b1;
        foreach (lo_s[i]) lo_q.push_back(lo_s[i]);
        foreach (hi_s[i]) hi_q.push_back(hi_s[i]);
    endtask

    // Score this cycle's handshakes and accepts, then advance one clock.
    task automatic tick();
        logic [4:0] e;
        if (lo_op_valid && op_ready) begin
            if (lo_q.size() == 0) begin
                check("lo_unexpected_op", {12'd0, lo_op_code}, 16'hFFFF);
            end else begin
                e = lo_q.pop_front();
                check("lo_code", {12'd0, lo_op_code}, {12'd0, e[3:0]});
                check("lo_last", {15'd0, lo_op_last}, {15'd0, e[4]});
            end
        end
        if (hi_op_valid && op_ready) begin
            if (hi_q.size() == 0) begin
                check("hi_unexpected_op", {12'd0, hi_op_code}, 16'hFFFF);
            end else begin
                e = hi_q.pop_front();
                check("hi_code", {12'd0, hi_op_code}, {12'd0, e[3:0]});
                check("hi_last", {15'd0, hi_op_last}, {15'd0, e[4]});
            end
        end
        exp_err = 1'b0;
        if (in_valid && lo_in_ready) begin
            if (in_f != 14'd0) push_vec(in_f);
            else exp_err = 1'b1;
        end
        @(posedge clk);
        #1;
        check("lo_err_empty", {15'd0, lo_err_empty}, {15'd0, exp_err});
        check("hi_err_empty", {15'd0, hi_err_empty}, {15'd0, exp_err});
    endtask

    task automatic drain();
        int budget = 100;
        while ((lo_q.size() != 0 || hi_q.size() != 0) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_timeout", {15'd0, (budget == 0)}, 16'd0);
        check("idle_valid_lo", {15'd0, lo_op_valid}, 16'd0);
        check("idle_valid_hi", {15'd0, hi_op_valid}, 16'd0);
        check("idle_in_ready", {15'd0, lo_in_ready}, 16'd1);
    endtask

    task automatic send(input logic [13:0] v);
        in_f = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_f = 14'h3A5A;
    endtask

    initial begin
        int budget;
        op_map = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                   4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
        rst_n = 1'b0; in_f = 14'd0; in_valid = 1'b0; op_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {15'd0, lo_op_valid}, 16'd0);
        check("rst_code", {12'd0, lo_op_code}, 16'd0);
        check("rst_last", {15'd0, lo_op_last}, 16'd0);
        check("rst_err", {15'd0, lo_err_empty}, 16'd0);
        check("rst_in_ready", {15'd0, lo_in_ready}, 16'd1);
        rst_n = 1'b1;
        tick();

        // Single function line.
        send(14'h0001);
        check("single_valid", {15'd0, lo_op_valid}, 16'd1);
        drain();

        // F9 + F13 in both orders.
        send(14'h2200);
        drain();

        // All lines, then a chained vector during the last handshake.
        send(14'h3FFF);
        budget = 40;
        while (!(lo_op_valid && lo_op_last) && budget > 0) begin
            tick();
            budget--;
        end
        check("chain_reach_last", {15'd0, (budget == 0)}, 16'd0);
        check("chain_in_ready", {15'd0, lo_in_ready}, 16'd1);
        send(14'h0010);
        check("chain_valid", {15'd0, lo_op_valid}, 16'd1);
        check("chain_code", {12'd0, lo_op_code}, 16'h0004);
        drain();

        // Empty vector.
        send(14'h0000);
        check("empty_valid", {15'd0, lo_op_valid}, 16'd0);
        check("empty_in_ready", {15'd0, lo_in_ready}, 16'd1);
        tick();

        // Backpressure with in_f wiggling while not ready.
        op_ready = 1'b0;
        send(14'h0006);
        for (int i = 0; i < 5; i++) begin
            in_f = 14'($urandom);
            in_valid = 1'b1;
            check("bp_valid", {15'd0, lo_op_valid}, 16'd1);
            check("bp_code", {12'd0, lo_op_code}, 16'h0001);
            check("bp_in_ready", {15'd0, lo_in_ready}, 16'd0);
            tick();
        end
        in_valid = 1'b0;
        op_ready = 1'b1;
        drain();

        // Asynchronous reset during the second opcode.
        send(14'h0007);
        tick();
        check("rst_mid_valid_pre", {15'd0, lo_op_valid}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid_lo", {15'd0, lo_op_valid}, 16'd0);
        check("rst_mid_valid_hi", {15'd0, hi_op_valid}, 16'd0);
        lo_q.delete();
        hi_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {15'd0, lo_in_ready}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_valid", {15'd0, lo_op_valid}, 16'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_encoder_seq.md
# instruction_encoder_seq

Sequential instruction encoder: the inverse of the team's 4-to-14 one-hot instruction decoder. It accepts a 14-bit function-line vector, which may have several lines set, over a valid/ready handshake. It then emits the corresponding 4-bit opcodes one per handshake, ordered by function index, on a registered valid/ready output stream. It sits between the control/test logic that selects operations and the opcode bus consumed by the decoder.

## Interface
- `HIGH_FIRST`, default 0: emission order; 0 = lowest function index first, 1 = highest first.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_f` in 14: function-line vector; bit i requests function i.
- `in_valid` in 1: `in_f` is valid.
- `in_ready` out 1: block can accept a vector this cycle.
- `op_code` out 4: encoded opcode.
- `op_valid` out 1: `op_code` is valid.
- `op_ready` in 1: consumer accepts `op_code`.
- `op_last` out 1: current opcode is the final one from its vector.
- `err_empty` out 1: one-cycle pulse when an all-zero vector is accepted.

## Operation
- Fixed function-to-opcode map:
  - F0..F8 map to 0x0..0x8.
  - F9 maps to 0xA, F10 to 0xB, F11 to 0xC, F12 to 0xD, F13 to 0xF.
  - Opcodes 0x9 and 0xE are never emitted.
- Two states: IDLE and EMIT.
- IDLE:
  - `in_ready` = 1.
  - On accept (`in_valid` && `in_ready`) with `in_f` != 0: load `in_f` into the pending register, then go to EMIT.
  - On accept with `in_f` == 0: assert `err_empty` next cycle, stay in IDLE, emit nothing.
- EMIT:
  - `op_code` is the map of the selected pending bit: lowest set bit, or highest if `HIGH_FIRST`=1.
  - `op_last` = 1 when exactly one pending bit remains.
  - On `op_valid` && `op_ready`: clear the selected bit. If it was the last bit, go to IDLE.
- Zero-bubble chaining: `in_ready` is also 1 in EMIT during the cycle the last opcode handshakes (`op_valid` && `op_ready` && `op_last`).
  - If a new non-zero vector is accepted in that cycle, stay in EMIT with the new pending vector.
  - If the new vector is zero, pulse `err_empty` and go to IDLE.
- `in_f` is sampled only on accept. Changes to it while `in_ready` = 0 have no effect.
- `op_code` and `op_last` are held stable while `op_valid` = 1 and `op_ready` = 0.

## Timing
- Reset values:
  - State = IDLE, pending = 0.
  - `op_valid` = 0, `op_code` = 0x0, `op_last` = 0, `err_empty` = 0.
  - `in_ready` = 1 (combinational from state).
- Latency: accept at edge N gives `op_valid` = 1 with the first opcode after edge N.
- Throughput: one opcode per cycle while `op_ready` = 1. A vector with k set bits occupies k cycles, with no gap to the next vector.
- All outputs except `in_ready` are registered.
- `in_ready` is combinational from state, `op_last` and `op_ready`. It has no path from `in_valid`.
- Reset assertion mid-EMIT:
  - Immediately drops `op_valid` and discards pending bits.
  - After release, the block is in IDLE with no residual output.

## Structure
- Shared package `instr_pkg`:
  - Opcode width constant (4) and function count constant (14).
  - Opcode constants OP_F0..OP_F13.
  - The index-to-opcode function used here, which the decoder side also uses.
- One sub-module, `instr_bit_pick`: combinational priority picker. It takes the pending vector and `HIGH_FIRST` and returns the selected index, a one-hot clear mask and a single-bit-remaining flag.
- The top level holds the FSM, the pending register and the output register.

## Test plan
- `in_f` = 14'h0001, `op_ready` = 1 → one cycle after accept: `op_code` = 0x0, `op_last` = 1. Next cycle `op_valid` = 0.
- `in_f` = 14'h2200 (F9, F13), `HIGH_FIRST` = 0 → 0xA (`op_last` = 0), then 0xF (`op_last` = 1) on consecutive cycles. With `HIGH_FIRST` = 1 → 0xF, then 0xA.
- `in_f` = 14'h3FFF → 14 opcodes in order 0,1,…,8,A,B,C,D,F on consecutive cycles; 0x9 and 0xE never appear. A second vector 14'h0010, presented with the last handshake, yields 0x4 on the very next cycle.
- `in_f` = 0 accepted → `err_empty` high for exactly one cycle, `op_valid` stays 0, `in_ready` stays 1.
- Backpressure: `in_f` = 14'h0006 with `op_ready` low for 5 cycles → `op_code` = 0x1 and `op_valid` held stable; `in_ready` = 0. After release: 0x1, then 0x2 with `op_last` = 1.
- Reset: `rst_n` driven low asynchronously during the second opcode of 14'h0007 → `op_valid` falls before the next clock edge. After release: `in_ready` = 1 and no further opcodes are emitted.
